// File: rtl/jt51_timer_ctrl.sv
// jt51_timer_ctrl: CPU write decoder for timer A/B registers, busy status and CSM key-on
module jt51_timer_ctrl #(
    parameter int BUSY_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       zero,
    input  logic       wr,
    input  logic       a0,
    input  logic [7:0] din,
    input  logic       flag_A,
    input  logic       flag_B,
    input  logic       overflow_A,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       enable_irq_A,
    output logic       enable_irq_B,
    output logic       csm,
    output logic       csm_kon,
    output logic       busy,
    output logic [7:0] dout
);
    logic [7:0] addr_q, addr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] va_q, va_d;
    logic [7:0] vb_q, vb_d;
    logic [4:0] ctrl_q, ctrl_d;
    logic [1:0] clr_q, clr_d;
    logic       kon_q, kon_d;
    logic       wr_ok, sel_14;

    assign busy    = cnt_q != 8'd0;
    assign wr_ok   = wr && a0 && !busy;
    assign sel_14  = wr_ok && addr_q == 8'h14;

    // next state: data writes are judged against the pre-clock busy; key-on only moves on sample strobes
    always_comb begin
        addr_d = (wr && !a0) ? din : addr_q;
        cnt_d  = wr_ok ? BUSY_CYCLES[7:0] : (cen && busy) ? cnt_q - 8'd1 : cnt_q;
        va_d   = (wr_ok && addr_q == 8'h10) ? {din, va_q[1:0]} :
                 (wr_ok && addr_q == 8'h11) ? {va_q[9:2], din[1:0]} : va_q;
        vb_d   = (wr_ok && addr_q == 8'h12) ? din : vb_q;
        ctrl_d = sel_14 ? {din[7], din[3:0]} : ctrl_q;
        clr_d  = sel_14 ? din[5:4] : 2'b00;
        kon_d  = (cen && zero) ? (overflow_A && ctrl_q[4]) : kon_q;
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= 8'h00;
            cnt_q  <= 8'd0;
            va_q   <= 10'd0;
            vb_q   <= 8'd0;
            ctrl_q <= 5'd0;
            clr_q  <= 2'd0;
            kon_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            va_q   <= va_d;
            vb_q   <= vb_d;
            ctrl_q <= ctrl_d;
            clr_q  <= clr_d;
            kon_q  <= kon_d;
        end
    end

    assign value_A      = va_q;
    assign value_B      = vb_q;
    assign csm          = ctrl_q[4];
    assign enable_irq_B = ctrl_q[3];
    assign enable_irq_A = ctrl_q[2];
    assign load_B       = ctrl_q[1];
    assign load_A       = ctrl_q[0];
    assign clr_flag_B   = clr_q[1];
    assign clr_flag_A   = clr_q[0];
    assign csm_kon      = kon_q;
    assign dout         = {busy, 5'b0, flag_B, flag_A};
endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// tb_jt51_timer_ctrl: table-driven and sequence checks of the timer register controller
module tb_jt51_timer_ctrl;
    logic       clk = 1'b0, rst = 1'b1, cen = 1'b1, zero = 1'b0, wr = 1'b0, a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       flag_A = 1'b0, flag_B = 1'b0, overflow_A = 1'b0;
    logic [9:0] value_A;
    logic [7:0] value_B, dout;
    logic       load_A, load_B, clr_flag_A, clr_flag_B, enable_irq_A, enable_irq_B;
    logic       csm, csm_kon, busy;

    jt51_timer_ctrl #(.BUSY_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .cen(cen), .zero(zero), .wr(wr), .a0(a0), .din(din),
        .flag_A(flag_A), .flag_B(flag_B), .overflow_A(overflow_A),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .enable_irq_A(enable_irq_A), .enable_irq_B(enable_irq_B),
        .csm(csm), .csm_kon(csm_kon), .busy(busy), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [9:0] va;
        logic [7:0] vb;
        logic [4:0] ctrl;
        logic [1:0] clr;
    } vec_t;

    vec_t        vecs[7];
    logic [25:0] sb_q[$];
    logic [25:0] snap, exp_snap;
    int          n_cmp = 0, n_bad = 0;

    assign snap = {value_A, value_B, csm, enable_irq_B, enable_irq_A, load_B, load_A,
                   clr_flag_B, clr_flag_A, busy};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        wr = 1'b1; a0 = 1'b0; din = a;
        tick;
        a0 = 1'b1; din = d;
        tick;
        wr = 1'b0; a0 = 1'b0;
    endtask

    task automatic count_busy(inout int n, inout int mir);
        for (int i = 0; i < 100 && busy; i++) begin
            tick;
            if (busy) n++;
            if (dout[7] !== busy) mir++;
        end
    endtask

    task automatic strobe(input logic ov);
        zero = 1'b1; overflow_A = ov;
        tick;
        zero = 1'b0; overflow_A = 1'b0;
    endtask

    initial begin
        int n, mir;
        vecs[0] = '{8'h10, 8'hAB, 10'h2AC, 8'h00, 5'b00000, 2'b00};
        vecs[1] = '{8'h11, 8'h03, 10'h2AF, 8'h00, 5'b00000, 2'b00};
        vecs[2] = '{8'h12, 8'h55, 10'h2AF, 8'h55, 5'b00000, 2'b00};
        vecs[3] = '{8'h14, 8'h3F, 10'h2AF, 8'h55, 5'b01111, 2'b11};
        vecs[4] = '{8'h14, 8'h0F, 10'h2AF, 8'h55, 5'b01111, 2'b00};
        vecs[5] = '{8'h20, 8'hFF, 10'h2AF, 8'h55, 5'b01111, 2'b00};
        vecs[6] = '{8'h14, 8'h81, 10'h2AF, 8'h55, 5'b10001, 2'b00};
        repeat (3) tick;
        chk("reset_outputs", {snap, csm_kon, dout}, 0);
        rst = 1'b0;
        tick;
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back({vecs[i].va, vecs[i].vb, vecs[i].ctrl, vecs[i].clr, 1'b1});
            wr_reg(vecs[i].addr, vecs[i].data);
            exp_snap = sb_q.pop_front();
            chk($sformatf("vec%0d_regs", i), snap, exp_snap);
            n = 1; mir = 0;
            tick;
            chk($sformatf("vec%0d_clr_release", i), {clr_flag_B, clr_flag_A}, 0);
            if (busy) n++;
            count_busy(n, mir);
            chk($sformatf("vec%0d_busy_len", i), n, 32);
            chk($sformatf("vec%0d_dout_mirror", i), mir, 0);
        end
        wr_reg(8'h12, 8'h66);
        n = 1; mir = 0;
        repeat (4) begin tick; if (busy) n++; end
        wr = 1'b1; a0 = 1'b1; din = 8'h77;
        tick;
        if (busy) n++;
        wr = 1'b0; a0 = 1'b0;
        count_busy(n, mir);
        chk("dropped_write_vb", value_B, 8'h66);
        chk("dropped_write_busy_len", n, 32);
        wr_reg(8'h20, 8'h00);
        cen = 1'b0;
        repeat (40) tick;
        chk("busy_held_without_cen", busy, 1);
        cen = 1'b1;
        n = 1; mir = 0;
        count_busy(n, mir);
        chk("busy_len_after_cen_gap", n, 32);
        strobe(1'b1);
        chk("kon_set", csm_kon, 1);
        repeat (3) tick;
        chk("kon_hold_between_strobes", csm_kon, 1);
        strobe(1'b0);
        chk("kon_clear", csm_kon, 0);
        strobe(1'b1);
        strobe(1'b1);
        chk("kon_retrigger_hold", csm_kon, 1);
        strobe(1'b0);
        chk("kon_retrigger_clear", csm_kon, 0);
        cen = 1'b0;
        strobe(1'b1);
        chk("kon_needs_cen", csm_kon, 0);
        cen = 1'b1;
        strobe(1'b1);
        wr_reg(8'h14, 8'h00);
        n = 1; mir = 0;
        count_busy(n, mir);
        chk("csm_cleared", csm, 0);
        chk("kon_not_truncated", csm_kon, 1);
        strobe(1'b0);
        chk("kon_end_after_csm_clear", csm_kon, 0);
        strobe(1'b1);
        chk("kon_off_when_csm0", csm_kon, 0);
        flag_A = 1'b1;
        #1;
        chk("dout_flags", dout, 8'h01);
        flag_A = 1'b0; flag_B = 1'b1;
        #1;
        chk("dout_flagB", dout, 8'h02);
        flag_B = 1'b0;
        wr_reg(8'h14, 8'h81);
        strobe(1'b1);
        chk("pre_reset_busy_kon", {busy, csm_kon}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {snap, csm_kon, dout}, 0);
        tick;
        rst = 1'b0;
        tick;
        wr_reg(8'h12, 8'h5A);
        chk("post_reset_write", {value_B, busy}, {8'h5A, 1'b1});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
